// File: rtl/pipe_bus_ctrl_pkg.sv
// Shared defines for the pipeline stall controller: stall encodings, FSM
// state encoding, bus owner constants and the small arbitration helpers.
package pipe_bus_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   // stall[5:0] = {WB, MEM, EX, ID, IF, PC}; WB is never stalled.
   localparam logic [5:0] STALL_MEM  = {NoStop, Stop,   Stop,   Stop,   Stop, Stop};
   localparam logic [5:0] STALL_EX   = {NoStop, NoStop, Stop,   Stop,   Stop, Stop};
   localparam logic [5:0] STALL_ID   = {NoStop, NoStop, NoStop, Stop,   Stop, Stop};
   localparam logic [5:0] STALL_NONE = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};

   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_IF_WAIT  = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_t;

   // Round-robin pick: with both requests pending, the one that did not own
   // the bus last time wins.
   function automatic logic pick_owner(input logic if_req,
                                       input logic mem_req,
                                       input logic last_owner);
      if (if_req && mem_req)
         return ~last_owner;
      else if (mem_req)
         return OWNER_MEM;
      else
         return OWNER_IF;
   endfunction

   function automatic logic [5:0] stall_vec(input logic mem_wait,
                                            input logic ex_req,
                                            input logic id_req,
                                            input logic if_wait);
      if (mem_wait)
         return STALL_MEM;
      else if (ex_req)
         return STALL_EX;
      else if (id_req || if_wait)
         return STALL_ID;
      else
         return STALL_NONE;
   endfunction

endpackage

// File: rtl/pipe_bus_ctrl_bus_watchdog.sv
// Wait-cycle counter for one bus cycle; hit flags the last permitted wait
// cycle (count == TIMEOUT-1).
module bus_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic hit
);

   localparam int W = $clog2(TIMEOUT);
   localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign hit = (cnt == LAST);

endmodule

// File: rtl/pipe_bus_ctrl.sv
// Single-bus arbiter between fetch and memory stages plus the pipeline stall
// vector generator; a watchdog aborts bus cycles that never see an ack.
import pipe_bus_ctrl_pkg::*;

module pipe_bus_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stallreq_from_id,
   input  logic       stallreq_from_ex,
   input  logic       if_req,
   input  logic       mem_req,
   input  logic       bus_ack,
   output logic       bus_cyc,
   output logic       bus_owner,
   output logic       if_done,
   output logic       mem_done,
   output logic       bus_err,
   output logic [5:0] stall
);

   state_t state;
   logic   last_owner;
   logic   cyc_q;
   logic   owner_q;

   logic   in_wait;
   logic   grant;
   logic   grant_owner;
   logic   wd_hit;
   logic   end_cycle;
   logic   if_wait;
   logic   mem_wait;

   assign in_wait     = (state != ST_IDLE);
   assign grant       = (state == ST_IDLE) && (if_req || mem_req);
   assign grant_owner = pick_owner(if_req, mem_req, last_owner);
   // An ack always ends the cycle; the watchdog only ends it when no ack came.
   assign end_cycle   = in_wait && (bus_ack || wd_hit);

   bus_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk  (clk),
      .rst  (rst),
      .clear(grant),
      .en   (in_wait && !end_cycle),
      .hit  (wd_hit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         last_owner <= OWNER_IF;
         cyc_q      <= 1'b0;
         owner_q    <= OWNER_IF;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  last_owner <= grant_owner;
                  owner_q    <= grant_owner;
                  cyc_q      <= 1'b1;
                  state      <= (grant_owner == OWNER_MEM) ? ST_MEM_WAIT : ST_IF_WAIT;
               end
            end
            ST_IF_WAIT, ST_MEM_WAIT: begin
               if (end_cycle) begin
                  cyc_q   <= 1'b0;
                  owner_q <= OWNER_IF;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               cyc_q   <= 1'b0;
               owner_q <= OWNER_IF;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Everything is gated with rst so the outputs read zero for the whole
   // reset assertion, including the input-driven stall terms.
   assign bus_cyc   = rst && cyc_q;
   assign bus_owner = rst && cyc_q && owner_q;
   assign if_done   = rst && end_cycle && (state == ST_IF_WAIT);
   assign mem_done  = rst && end_cycle && (state == ST_MEM_WAIT);
   assign bus_err   = rst && in_wait && wd_hit && !bus_ack;

   assign mem_wait  = mem_req && !mem_done;
   assign if_wait   = if_req && !if_done;
   assign stall     = rst ? stall_vec(mem_wait, stallreq_from_ex, stallreq_from_id, if_wait)
                          : STALL_NONE;

endmodule

// File: tb/tb_pipe_bus_ctrl.sv
// Directed bench for pipe_bus_ctrl: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares them.
module tb_pipe_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       stallreq_from_id = 1'b0;
   logic       stallreq_from_ex = 1'b0;
   logic       if_req = 1'b0;
   logic       mem_req = 1'b0;
   logic       bus_ack = 1'b0;
   logic       bus_cyc;
   logic       bus_owner;
   logic       if_done;
   logic       mem_done;
   logic       bus_err;
   logic [5:0] stall;

   localparam logic [5:0] S_MEM = 6'b011111;
   localparam logic [5:0] S_EX  = 6'b001111;
   localparam logic [5:0] S_ID  = 6'b000111;
   localparam logic [5:0] S_0   = 6'b000000;

   int checks = 0;
   int passes = 0;

   // Expected word: {bus_cyc, bus_owner, if_done, mem_done, bus_err, stall}
   logic [10:0] exp_q[$];
   string       name_q[$];

   pipe_bus_ctrl #(.TIMEOUT(16)) dut (
      .clk             (clk),
      .rst             (rst),
      .stallreq_from_id(stallreq_from_id),
      .stallreq_from_ex(stallreq_from_ex),
      .if_req          (if_req),
      .mem_req         (mem_req),
      .bus_ack         (bus_ack),
      .bus_cyc         (bus_cyc),
      .bus_owner       (bus_owner),
      .if_done         (if_done),
      .mem_done        (mem_done),
      .bus_err         (bus_err),
      .stall           (stall)
   );

   // Clock / reset
   always #5 clk = ~clk;

   function automatic logic [10:0] e(input logic cyc, input logic own,
                                     input logic ifd, input logic memd,
                                     input logic err, input logic [5:0] st);
      return {cyc, own, ifd, memd, err, st};
   endfunction

   // Driver: one call = one clock cycle of stimulus and its expected outputs.
   task automatic cyc(input logic r, input logic id, input logic ex,
                      input logic ifr, input logic memr, input logic ack,
                      input logic [10:0] exp_v, input string nm);
      @(posedge clk);
      #1;
      rst              = r;
      stallreq_from_id = id;
      stallreq_from_ex = ex;
      if_req           = ifr;
      mem_req          = memr;
      bus_ack          = ack;
      exp_q.push_back(exp_v);
      name_q.push_back(nm);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      logic [10:0] got;
      logic [10:0] want;
      string       nm;
      if (exp_q.size() > 0) begin
         want = exp_q.pop_front();
         nm   = name_q.pop_front();
         got  = {bus_cyc, bus_owner, if_done, mem_done, bus_err, stall};
         checks++;
         if (got === want)
            passes++;
         else
            $display("FAIL %s at %0t: got cyc/own/ifd/memd/err/stall=%b expected %b",
                     nm, $time, got, want);
      end
   end

   initial begin
      // Reset held with every request high: outputs forced to zero.
      cyc(0, 1, 1, 1, 1, 0, e(0, 0, 0, 0, 0, S_0),   "rst_hold0");
      cyc(0, 1, 1, 1, 1, 0, e(0, 0, 0, 0, 0, S_0),   "rst_hold1");
      cyc(1, 0, 0, 1, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "rst_release");

      // Both requests: MEM first (last_owner resets to IF), one IDLE, then IF.
      cyc(1, 0, 0, 1, 1, 0, e(1, 1, 0, 0, 0, S_MEM), "arb1_mem_wait");
      cyc(1, 0, 0, 1, 1, 1, e(1, 1, 0, 1, 0, S_ID),  "arb1_mem_ack");
      cyc(1, 0, 0, 1, 0, 0, e(0, 0, 0, 0, 0, S_ID),  "arb1_idle_gap");
      cyc(1, 0, 0, 1, 0, 0, e(1, 0, 0, 0, 0, S_ID),  "arb1_if_wait");
      cyc(1, 0, 0, 1, 0, 1, e(1, 0, 1, 0, 0, S_0),   "arb1_if_ack");

      // Both again: round-robin gives MEM again.
      cyc(1, 0, 0, 1, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "arb2_idle");
      cyc(1, 0, 0, 1, 1, 0, e(1, 1, 0, 0, 0, S_MEM), "arb2_mem_wait");
      cyc(1, 0, 0, 1, 1, 1, e(1, 1, 0, 1, 0, S_ID),  "arb2_mem_ack");
      cyc(1, 0, 0, 1, 0, 0, e(0, 0, 0, 0, 0, S_ID),  "arb2_idle_gap");

      // Fetch wait overlapped with an EX stall request.
      cyc(1, 0, 1, 1, 0, 0, e(1, 0, 0, 0, 0, S_EX),  "ex_if_wait1");
      cyc(1, 0, 1, 1, 0, 0, e(1, 0, 0, 0, 0, S_EX),  "ex_if_wait2");
      cyc(1, 0, 1, 1, 0, 1, e(1, 0, 1, 0, 0, S_EX),  "ex_if_ack");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "ex_idle");

      // Memory access alone, ack in the third wait cycle.
      cyc(1, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "mem_req_cycle");
      cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 0, 0, S_MEM), "mem_wait1");
      cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 0, 0, S_MEM), "mem_wait2");
      cyc(1, 0, 0, 0, 1, 1, e(1, 1, 0, 1, 0, S_0),   "mem_ack3");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "mem_after");

      // ID stall alone.
      cyc(1, 1, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_ID),  "id_stall");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "id_release");

      // Timeout: no ack, bus_err + mem_done in the 16th wait cycle.
      cyc(1, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "to_req");
      for (int i = 1; i <= 15; i++)
         cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 0, 0, S_MEM), $sformatf("to_wait%0d", i));
      cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 1, 1, S_0),   "to_wait16_err");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "to_after");

      // Ack exactly in the 16th wait cycle: normal completion.
      cyc(1, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "ackto_req");
      for (int i = 1; i <= 15; i++)
         cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 0, 0, S_MEM), $sformatf("ackto_wait%0d", i));
      cyc(1, 0, 0, 0, 1, 1, e(1, 1, 0, 1, 0, S_0),   "ackto_wait16");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "ackto_after");

      // Reset in the second MEM wait cycle, then a late ack.
      cyc(1, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_MEM), "mrst_req");
      cyc(1, 0, 0, 0, 1, 0, e(1, 1, 0, 0, 0, S_MEM), "mrst_wait1");
      cyc(0, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_0),   "mrst_wait2_rst");
      cyc(0, 0, 0, 0, 1, 0, e(0, 0, 0, 0, 0, S_0),   "mrst_hold");
      cyc(1, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, S_0),   "mrst_late_ack1");
      cyc(1, 0, 0, 0, 0, 1, e(0, 0, 0, 0, 0, S_0),   "mrst_late_ack2");
      cyc(1, 0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, S_0),   "mrst_quiet");

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++)
         @(posedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
